pipe_tx_gearbox: RTL and testbench

PIPE_TX_GEARBOX -- requirements
Module: pipe_tx_gearbox

---
 rtl/pipe_tx_gearbox_if.sv | 13 +
 rtl/pipe_tx_gearbox.sv | 220 ++++++++++++++++++++++
 tb/tb_pipe_tx_gearbox.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_tx_gearbox_if.sv
// Gearbox stream bundle: 32-bit scrambled words in, registered PIPE TX beats out.
interface pipe_tx_gearbox_if;
    logic [31:0] in_data;
    logic [3:0]  in_k;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] TxData;
    logic [3:0]  TxDataK;
    logic        TxDataValid;

    modport master (output in_data, in_k, in_valid, input in_ready, TxData, TxDataK, TxDataValid);
    modport slave  (input in_data, in_k, in_valid, output in_ready, TxData, TxDataK, TxDataValid);
endinterface

// File: rtl/pipe_tx_gearbox.sv
// PIPE TX gearbox: 32-bit words split into W-bit beats per generation; first beat two edges after accept.
// Backpressure on input only: in_ready drops at FIFO_DEPTH words held, on a bad generation, or in FLUSH.

// Generic synchronous FIFO with combinational head read and single-cycle flush.
module pipe_tx_gearbox_fifo #(
    parameter int DW    = 36,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic [LW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module pipe_tx_gearbox #(
    parameter int PIPE_WIDTH_GEN1 = 8,
    parameter int PIPE_WIDTH_GEN2 = 8,
    parameter int PIPE_WIDTH_GEN3 = 16,
    parameter int PIPE_WIDTH_GEN4 = 32,
    parameter int PIPE_WIDTH_GEN5 = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                              pclk,
    input  logic                              reset,
    input  logic [2:0]                        generation,
    pipe_tx_gearbox_if.slave                  tx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              err_bad_gen
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

    state_t        state_q, state_nxt;
    logic [2:0]    gen_q;
    logic          bad_q;
    logic [1:0]    beat_q, beat_nxt;
    logic [31:0]   word_q, word_nxt;
    logic [3:0]    wk_q, wk_nxt;
    logic [31:0]   txd_nxt;
    logic [3:0]    txk_nxt;
    logic          txv_nxt;
    logic          gen_legal, gen_change, flush, run;
    logic          push, pop, fifo_empty;
    logic [35:0]   fifo_dat;
    logic [LW-1:0] fifo_cnt;
    int            width;
    logic [1:0]    last_beat;

    function automatic int width_of(input logic [2:0] g);
        case (g)
            3'd2:    width_of = PIPE_WIDTH_GEN2;
            3'd3:    width_of = PIPE_WIDTH_GEN3;
            3'd4:    width_of = PIPE_WIDTH_GEN4;
            3'd5:    width_of = PIPE_WIDTH_GEN5;
            default: width_of = PIPE_WIDTH_GEN1;
        endcase
    endfunction

    assign gen_legal   = (generation >= 3'd1) && (generation <= 3'd5);
    assign err_bad_gen = !gen_legal;
    // A return from an illegal generation always goes through FLUSH, even to the old value.
    assign gen_change  = bad_q || (generation != gen_q);
    assign flush       = (state_q != FLUSH) && gen_legal && gen_change;
    assign run         = gen_legal && !gen_change;
    assign width       = width_of(gen_q);
    assign last_beat   = 2'(32 / width - 1);
    assign fifo_empty  = (fifo_cnt == '0);

    // The word in the holding register still counts as buffered until its last beat leaves.
    assign fifo_level  = fifo_cnt + {{(LW-1){1'b0}}, (state_q == SHIFT)};
    assign tx.in_ready = (fifo_level < LW'(FIFO_DEPTH)) && gen_legal && (state_q != FLUSH);
    assign push        = tx.in_valid && tx.in_ready;

    pipe_tx_gearbox_fifo #(.DW(36), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
        .pclk     (pclk),
        .reset    (reset),
        .flush    (flush),
        .push     (push),
        .push_dat ({tx.in_k, tx.in_data}),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_cnt)
    );

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (state_q == FLUSH) begin
            state_nxt = IDLE;
        end else if (!gen_legal) begin
            state_nxt = state_q;
        end else if (gen_change) begin
            state_nxt = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_nxt = SHIFT;
                SHIFT:   if (beat_q == last_beat && fifo_empty) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pop      = 1'b0;
        beat_nxt = beat_q;
        word_nxt = word_q;
        wk_nxt   = wk_q;
        txd_nxt  = '0;
        txk_nxt  = '0;
        txv_nxt  = 1'b0;
        if (flush) begin
            beat_nxt = '0;
            word_nxt = '0;
            wk_nxt   = '0;
        end else if (run) begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop                = 1'b1;
                        {wk_nxt, word_nxt} = fifo_dat;
                        beat_nxt           = '0;
                    end
                end
                SHIFT: begin
                    txv_nxt = 1'b1;
                    case (width)
                        8: begin
                            txd_nxt = {24'b0, word_q[{beat_q, 3'b000} +: 8]};
                            txk_nxt = {3'b0, wk_q[beat_q]};
                        end
                        16: begin
                            txd_nxt = {16'b0, word_q[{beat_q[0], 4'b0000} +: 16]};
                            txk_nxt = {2'b0, wk_q[{beat_q[0], 1'b0} +: 2]};
                        end
                        default: begin
                            txd_nxt = word_q;
                            txk_nxt = wk_q;
                        end
                    endcase
                    // Reload on the last beat so the next word follows with no bubble.
                    if (beat_q == last_beat) begin
                        beat_nxt = '0;
                        if (!fifo_empty) begin
                            pop                = 1'b1;
                            {wk_nxt, word_nxt} = fifo_dat;
                        end
                    end else begin
                        beat_nxt = beat_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            beat_q         <= '0;
            word_q         <= '0;
            wk_q           <= '0;
            gen_q          <= 3'd1;
            bad_q          <= 1'b0;
            tx.TxData      <= '0;
            tx.TxDataK     <= '0;
            tx.TxDataValid <= 1'b0;
        end else begin
            beat_q         <= beat_nxt;
            word_q         <= word_nxt;
            wk_q           <= wk_nxt;
            tx.TxData      <= txd_nxt;
            tx.TxDataK     <= txk_nxt;
            tx.TxDataValid <= txv_nxt;
            if (!gen_legal) begin
                bad_q <= 1'b1;
            end else if (flush) begin
                bad_q <= 1'b0;
                gen_q <= generation;
            end
        end
    end
endmodule

// File: tb/tb_pipe_tx_gearbox.sv
// Directed bench for pipe_tx_gearbox: hand-computed beats per generation, flush, bad generation, reset.
module tb_pipe_tx_gearbox;
    logic       pclk = 1'b0;
    logic       reset;
    logic [2:0] generation;
    logic [2:0] fifo_level;
    logic       err_bad_gen;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic        mon_en = 1'b0;
    logic [35:0] mon_q[$];
    int          cyc_q[$];

    logic [7:0]  g1_exp  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  g2_exp  [4] = '{8'h21, 8'h43, 8'h65, 8'h87};
    logic [31:0] s_words [6] = '{32'h1A2B3C4D, 32'h55667788, 32'h99AABBCC,
                                 32'hDDEEFF00, 32'h01234567, 32'h89ABCDEF};
    logic [3:0]  s_ks    [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};

    pipe_tx_gearbox_if bus();

    pipe_tx_gearbox #(.FIFO_DEPTH(4)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .generation  (generation),
        .tx          (bus),
        .fifo_level  (fifo_level),
        .err_bad_gen (err_bad_gen)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc = cyc + 1;

    always @(negedge pclk) begin
        if (mon_en && bus.TxDataValid) begin
            mon_q.push_back({bus.TxDataK, bus.TxData});
            cyc_q.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] d, input logic [3:0] k);
        check_val({tag, "_vld"}, 36'(bus.TxDataValid), 36'd1);
        check_val({tag, "_dat"}, 36'(bus.TxData), 36'(d));
        check_val({tag, "_k"},   36'(bus.TxDataK), 36'(k));
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_vld"}, 36'(bus.TxDataValid), 36'd0);
        check_val({tag, "_dat"}, 36'(bus.TxData), 36'd0);
        check_val({tag, "_k"},   36'(bus.TxDataK), 36'd0);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic push1(input logic [31:0] d, input logic [3:0] k);
        int w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge pclk);
            w++;
        end
        if (!bus.in_ready) begin
            check_val("push_ready_timeout", 36'(bus.in_ready), 36'd1);
            return;
        end
        bus.in_data  = d;
        bus.in_k     = k;
        bus.in_valid = 1'b1;
        @(negedge pclk);
        bus.in_valid = 1'b0;
    endtask

    task automatic set_gen(input logic [2:0] g);
        generation = g;
        @(negedge pclk);
        @(negedge pclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int max_lvl;
        int vcnt;
        logic acc;
        logic stall;
        logic [31:0] wd;
        logic [3:0]  kk;

        reset        = 1'b1;
        generation   = 3'd1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_k     = '0;

        // Reset state
        @(negedge pclk);
        check_idle("rst");
        check_val("rst_level", 36'(fifo_level), 36'd0);
        check_val("rst_err", 36'(err_bad_gen), 36'd0);
        reset = 1'b0;
        @(negedge pclk);
        check_val("rst_ready", 36'(bus.in_ready), 36'd1);

        // Gen4: one 32-bit beat, two edges after accept
        set_gen(3'd4);
        push1(32'hA1B2C3D4, 4'h1);
        check_val("g4_level", 36'(fifo_level), 36'd1);
        @(negedge pclk);
        check_val("g4_early", 36'(bus.TxDataValid), 36'd0);
        @(negedge pclk);
        check_beat("g4_beat", 32'hA1B2C3D4, 4'h1);
        @(negedge pclk);
        check_idle("g4_after");

        // Gen1: four byte beats
        set_gen(3'd1);
        push1(32'h44332211, 4'h8);
        @(negedge pclk);
        check_val("g1_early", 36'(bus.TxDataValid), 36'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check_beat($sformatf("g1_b%0d", i), {24'b0, g1_exp[i]}, (i == 3) ? 4'h1 : 4'h0);
        end
        @(negedge pclk);
        check_idle("g1_after");

        // Gen3: continuous stream of 6 words, FIFO fills, output back-to-back
        set_gen(3'd3);
        mon_q.delete();
        cyc_q.delete();
        mon_en  = 1'b1;
        idx     = 0;
        max_lvl = 0;
        stall   = 1'b0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = s_words[idx];
            bus.in_k     = s_ks[idx];
            acc          = bus.in_ready;
            @(negedge pclk);
            if (acc) idx++;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (!bus.in_ready) stall = 1'b1;
        end
        bus.in_valid = 1'b0;
        check_val("g3_pushed", 36'(idx), 36'd6);
        check_val("g3_max_level", 36'(max_lvl), 36'd4);
        check_val("g3_ready_drop", 36'(stall), 36'd1);
        repeat (16) @(negedge pclk);
        mon_en = 1'b0;
        check_val("g3_beats", 36'(mon_q.size()), 36'd12);
        if (mon_q.size() == 12)
            check_val("g3_gapless", 36'(cyc_q[11] - cyc_q[0]), 36'd11);
        for (int j = 0; j < 12 && j < mon_q.size(); j++) begin
            wd = s_words[j / 2];
            kk = s_ks[j / 2];
            if (j % 2 == 0)
                check_val($sformatf("g3_b%0d", j), mon_q[j], {2'b0, kk[1:0], 16'b0, wd[15:0]});
            else
                check_val($sformatf("g3_b%0d", j), mon_q[j], {2'b0, kk[3:2], 16'b0, wd[31:16]});
        end

        // Gen1 with 3 words held, switch to Gen4: one FLUSH cycle
        set_gen(3'd1);
        push1(32'h0A0B0C0D, 4'h0);
        push1(32'h1A1B1C1D, 4'h0);
        push1(32'h2A2B2C2D, 4'h0);
        check_val("fl_level_before", 36'(fifo_level), 36'd3);
        generation = 3'd4;
        @(negedge pclk);
        check_idle("fl");
        check_val("fl_level", 36'(fifo_level), 36'd0);
        check_val("fl_ready", 36'(bus.in_ready), 36'd0);
        @(negedge pclk);
        check_val("fl_ready_after", 36'(bus.in_ready), 36'd1);
        check_val("fl_vld_after", 36'(bus.TxDataValid), 36'd0);
        push1(32'hDEADBEEF, 4'h3);
        @(negedge pclk);
        check_val("fl_early", 36'(bus.TxDataValid), 36'd0);
        @(negedge pclk);
        check_beat("fl_beat", 32'hDEADBEEF, 4'h3);
        @(negedge pclk);
        check_idle("fl_after");

        // Illegal generation, then recovery to Gen2 through FLUSH
        generation = 3'd6;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            check_val($sformatf("bad%0d_err", i), 36'(err_bad_gen), 36'd1);
            check_val($sformatf("bad%0d_ready", i), 36'(bus.in_ready), 36'd0);
            check_idle($sformatf("bad%0d", i));
        end
        generation = 3'd2;
        @(negedge pclk);
        check_val("rec_err", 36'(err_bad_gen), 36'd0);
        check_val("rec_flush_ready", 36'(bus.in_ready), 36'd0);
        check_val("rec_flush_vld", 36'(bus.TxDataValid), 36'd0);
        @(negedge pclk);
        check_val("rec_ready", 36'(bus.in_ready), 36'd1);
        push1(32'h87654321, 4'h2);
        @(negedge pclk);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check_beat($sformatf("g2_b%0d", i), {24'b0, g2_exp[i]}, (i == 1) ? 4'h1 : 4'h0);
        end
        @(negedge pclk);
        check_idle("g2_after");

        // Reset during beat 2 of a Gen1 word
        set_gen(3'd1);
        push1(32'h44332211, 4'h0);
        repeat (3) @(negedge pclk);
        check_beat("mid_b1", 32'h00000022, 4'h0);
        @(negedge pclk);
        check_beat("mid_b2", 32'h00000033, 4'h0);
        reset = 1'b1;
        #1;
        check_idle("mid_rst");
        check_val("mid_rst_level", 36'(fifo_level), 36'd0);
        @(negedge pclk);
        reset = 1'b0;
        vcnt  = 0;
        repeat (8) begin
            @(negedge pclk);
            if (bus.TxDataValid) vcnt++;
        end
        check_val("mid_no_partial", 36'(vcnt), 36'd0);
        push1(32'h000000A5, 4'h0);
        @(negedge pclk);
        @(negedge pclk);
        check_beat("mid_new_b0", 32'h000000A5, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
